// File: rtl/mat_mult_sched.sv
// -----------------------------------------------------------------------------
// mat_mult_sched
//   Shares one 8x8 multiply-accumulate datapath between two requesters that
//   each want a 2x2 8-bit matrix product. A round-robin arbiter picks one
//   requester at a time while the block is idle. The block then latches that
//   requester's operands and produces one element-product per cycle for
//   8 cycles. It presents the packed result, tagged with the owner's ID, on a
//   valid/ready channel until the consumer takes it.
//
// Ports
//   clk                   rising-edge clock
//   rst                   synchronous, active-high reset
//   reqN_valid   (in)     requester N offers an operand pair (N = 0, 1)
//   reqN_ready   (out)    requester N is accepted this cycle (combinational)
//   reqN_a/_b    (in,32)  packed {x00,x01,x10,x11}, x00 in [31:24]
//   res_valid    (out)    product available
//   res_ready    (in)     consumer takes the product
//   res_data     (out,32) packed product {r00,r01,r10,r11}; zero when not valid
//   res_id       (out)    requester that owns res_data; zero when not valid
// -----------------------------------------------------------------------------
module mat_mult_sched (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic        res_id
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MAC,
      ST_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] acc_q, acc_d;
   logic [2:0]  step_q, step_d;
   logic        owner_q, owner_d;
   logic        last_grant_q, last_grant_d;

   logic        grant;
   logic        accept;
   logic [7:0]  prod;
   logic [4:0]  acc_lsb;

   // Element (r,c) of a packed matrix sits at index 2r+c counted from the top
   // byte, so its lsb is 8*(3-(2r+c)) = {~r,~c,3'b000}.
   function automatic logic [7:0] elem(input logic [31:0] m, input logic r, input logic c);
      return m[{~r, ~c, 3'b000} +: 8];
   endfunction

   // Round robin: a lone valid wins outright; on contention the requester that
   // was not served last wins. The choice only matters while idle.
   always_comb begin
      if (req0_valid && req1_valid) begin
         grant = ~last_grant_q;
      end else begin
         grant = req1_valid;
      end
   end

   assign req0_ready = !rst && (state_q == ST_IDLE) && req0_valid && !grant;
   assign req1_ready = !rst && (state_q == ST_IDLE) && req1_valid &&  grant;
   assign accept     = req0_ready || req1_ready;

   // Step s walks i=s[2], j=s[1], k=s[0]; acc[i][j] += a[i][k]*b[k][j].
   // An 8-bit product keeps only the low byte, so all element math wraps.
   assign prod    = elem(a_q, step_q[2], step_q[0]) * elem(b_q, step_q[0], step_q[1]);
   assign acc_lsb = {~step_q[2], ~step_q[1], 3'b000};

   // NOTE: every signal assigned here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      b_d          = b_q;
      acc_d        = acc_q;
      step_d       = step_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               a_d          = grant ? req1_a : req0_a;
               b_d          = grant ? req1_b : req0_b;
               owner_d      = grant;
               last_grant_d = grant;
               acc_d        = '0;
               step_d       = '0;
               state_d      = ST_MAC;
            end
         end
         ST_MAC: begin
            acc_d[acc_lsb +: 8] = acc_q[acc_lsb +: 8] + prod;
            step_d              = step_q + 3'd1;
            if (step_q == 3'd7) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         a_q          <= '0;
         b_q          <= '0;
         acc_q        <= '0;
         step_q       <= '0;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;   // requester 0 wins the first contention
      end else begin
         state_q      <= state_d;
         a_q          <= a_d;
         b_q          <= b_d;
         acc_q        <= acc_d;
         step_q       <= step_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
      end
   end

   // The result is gated so that a partial accumulation is never visible.
   assign res_valid = (state_q == ST_DONE);
   assign res_data  = res_valid ? acc_q : '0;
   assign res_id    = res_valid & owner_q;

endmodule

// File: tb/tb_mat_mult_sched.sv
// -----------------------------------------------------------------------------
// tb_mat_mult_sched
//   Self-checking bench for mat_mult_sched: a table of directed vectors, hand
//   sequences for stall and mid-computation reset, and randomized traffic
//   scored against a cycle-level behavioural model of the arbiter and timing.
// -----------------------------------------------------------------------------
module tb_mat_mult_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        res_valid, res_ready, res_id;
   logic [31:0] res_data;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mat_mult_sched dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_id     (res_id)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Plain matrix product with every element reduced mod 256.
   function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
      int          ma [2][2];
      int          mb [2][2];
      int          sum;
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 2; j++) begin
            ma[i][j] = int'(a[8*(3-(2*i+j)) +: 8]);
            mb[i][j] = int'(b[8*(3-(2*i+j)) +: 8]);
         end
      end
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 2; j++) begin
            sum = ma[i][0]*mb[0][j] + ma[i][1]*mb[1][j];
            r[8*(3-(2*i+j)) +: 8] = 8'(sum % 256);
         end
      end
      return r;
   endfunction

   // Leaves the bench just after a falling edge with rst low and no valids.
   task automatic reset_dut();
      @(negedge clk);
      rst        = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      res_ready  = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // One transaction from a single requester with res_ready high.
   // Entered and left just after a falling edge.
   task automatic do_txn(input bit id, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string tag);
      int n;
      if (id) begin
         req1_valid = 1'b1; req1_a = a; req1_b = b;
      end else begin
         req0_valid = 1'b1; req0_a = a; req0_b = b;
      end
      #1;
      n = 0;
      while (!(id ? req1_ready : req0_ready) && n < 40) begin
         @(negedge clk); #1; n++;
      end
      check($sformatf("%s accept", tag), {31'b0, id ? req1_ready : req0_ready}, 32'd1);
      check($sformatf("%s other_ready", tag), {31'b0, id ? req0_ready : req1_ready}, 32'd0);
      @(negedge clk);
      // Operands may change freely once accepted.
      if (id) begin
         req1_valid = 1'b0; req1_a = $urandom; req1_b = $urandom;
      end else begin
         req0_valid = 1'b0; req0_a = $urandom; req0_b = $urandom;
      end
      #1;
      n = 1;
      while (!res_valid && n < 30) begin
         @(negedge clk); #1; n++;
      end
      check($sformatf("%s latency", tag), n, 32'd9);
      check($sformatf("%s res_data", tag), res_data, exp);
      check($sformatf("%s res_id", tag), {31'b0, res_id}, {31'b0, id});
      @(negedge clk); #1;
      check($sformatf("%s idle_after", tag), {31'b0, res_valid}, 32'd0);
   endtask

   // Cycle-by-cycle scoreboard. mode 0: both requesters always valid and
   // res_ready high. mode 1: random valids and random res_ready.
   // Must be entered right after reset release, just after a falling edge.
   task automatic run_model(input int cycles, input int mode);
      bit          busy = 1'b0;
      bit          lg   = 1'b1;
      int          since = 0;
      int          cyc   = 0;
      int          nacc  = 0;
      logic [31:0] expq [$];
      bit          idq  [$];
      bit          g, e0, e1, ev;
      while ((cyc < cycles || busy || req0_valid || req1_valid) && cyc < cycles + 400) begin
         #1;
         g  = (req0_valid && req1_valid) ? !lg : req1_valid;
         e0 = !busy && req0_valid && !g;
         e1 = !busy && req1_valid &&  g;
         ev = busy && since >= 9;
         check("rr req0_ready", {31'b0, req0_ready}, {31'b0, e0});
         check("rr req1_ready", {31'b0, req1_ready}, {31'b0, e1});
         check("rr res_valid", {31'b0, res_valid}, {31'b0, ev});
         if (ev && expq.size() > 0) begin
            check("rr res_data", res_data, expq[0]);
            check("rr res_id", {31'b0, res_id}, {31'b0, idq[0]});
         end
         if (busy) begin
            if (ev && res_ready) begin
               busy = 1'b0;
               void'(expq.pop_front());
               void'(idq.pop_front());
            end else begin
               since++;
            end
         end
         if (e0 || e1) begin
            busy  = 1'b1;
            since = 1;
            lg    = e1;
            expq.push_back(e1 ? model_mul(req1_a, req1_b) : model_mul(req0_a, req0_b));
            idq.push_back(e1);
            if (mode == 0) begin
               check("rr alternation", {31'b0, e1}, 32'(nacc % 2));
            end
            nacc++;
         end
         @(negedge clk);
         cyc++;
         if (!req0_valid || e0) begin
            req0_valid = (cyc < cycles) && (mode == 0 || $urandom_range(0, 2) == 0);
            req0_a = $urandom; req0_b = $urandom;
         end
         if (!req1_valid || e1) begin
            req1_valid = (cyc < cycles) && (mode == 0 || $urandom_range(0, 2) == 0);
            req1_a = $urandom; req1_b = $urandom;
         end
         res_ready = (mode == 0) || ($urandom_range(0, 3) != 0);
      end
      check("rr drained", {31'b0, busy}, 32'd0);
      res_ready = 1'b1;
   endtask

   typedef struct {
      bit          id;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int          n;
      logic [31:0] held_data;
      logic [31:0] stall_exp;

      vecs[0] = '{1'b0, 32'h01020304, 32'h05060708, 32'h13162B32};  // {19,22,43,50}
      vecs[1] = '{1'b1, 32'hC8000001, 32'h02000001, 32'h90000001};  // 200*2 wraps to 144
      vecs[2] = '{1'b0, 32'h10100000, 32'h10001000, 32'h00000000};  // 256+256 wraps to 0
      vecs[3] = '{1'b1, 32'h01000001, 32'h09080706, 32'h09080706};  // identity
      vecs[4] = '{1'b0, 32'hFFFFFFFF, 32'h01010101, 32'hFEFEFEFE};  // 255+255 wraps to 254
      vecs[5] = '{1'b1, 32'h00000000, 32'hFFFFFFFF, 32'h00000000};  // zero operand

      // Reset with both requesters already waiting.
      rst        = 1'b1;
      res_ready  = 1'b1;
      req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom;
      req1_valid = 1'b1; req1_a = $urandom; req1_b = $urandom;
      repeat (2) @(negedge clk);
      #1;
      check("reset req0_ready", {31'b0, req0_ready}, 32'd0);
      check("reset req1_ready", {31'b0, req1_ready}, 32'd0);
      check("reset res_valid", {31'b0, res_valid}, 32'd0);
      check("reset res_data", res_data, 32'd0);
      check("reset res_id", {31'b0, res_id}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Continuous contention straight out of reset: 0,1,0,1...
      run_model(300, 0);

      // Directed vectors.
      reset_dut();
      foreach (vecs[v]) begin
         do_txn(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].exp, $sformatf("vec%0d", v));
      end

      // Result stall: hold res_ready low for 20 cycles with both valids high.
      res_ready  = 1'b0;
      req0_valid = 1'b1; req0_a = 32'h0A0B0C0D; req0_b = 32'h01020304;
      stall_exp  = model_mul(32'h0A0B0C0D, 32'h01020304);
      #1;
      n = 0;
      while (!req0_ready && n < 40) begin
         @(negedge clk); #1; n++;
      end
      check("stall accept", {31'b0, req0_ready}, 32'd1);
      @(negedge clk);
      req0_valid = 1'b0;
      #1;
      n = 1;
      while (!res_valid && n < 30) begin
         @(negedge clk); #1; n++;
      end
      check("stall latency", n, 32'd9);
      req0_valid = 1'b1; req0_a = 32'h01020304; req0_b = 32'h05060708;
      req1_valid = 1'b1; req1_a = 32'h02020202; req1_b = 32'h03030303;
      #1;
      held_data = res_data;
      check("stall data", held_data, stall_exp);
      for (int c = 0; c < 20; c++) begin
         check($sformatf("stall c%0d res_valid", c), {31'b0, res_valid}, 32'd1);
         check($sformatf("stall c%0d res_data", c), res_data, stall_exp);
         check($sformatf("stall c%0d res_id", c), {31'b0, res_id}, 32'd0);
         check($sformatf("stall c%0d readys", c), {30'b0, req1_ready, req0_ready}, 32'd0);
         @(negedge clk); #1;
      end
      res_ready = 1'b1;
      #1;
      check("release handshake res_valid", {31'b0, res_valid}, 32'd1);
      check("release handshake readys", {30'b0, req1_ready, req0_ready}, 32'd0);
      @(negedge clk); #1;
      // req0 was served last, so req1 wins the very next idle cycle.
      check("release idle res_valid", {31'b0, res_valid}, 32'd0);
      check("release grant req1", {31'b0, req1_ready}, 32'd1);
      check("release grant req0", {31'b0, req0_ready}, 32'd0);

      // Reset while req1's work is at MAC step 4 (accept + 5 cycles).
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst readys", {30'b0, req1_ready, req0_ready}, 32'd0);
      check("midrst res_valid", {31'b0, res_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("postrst res_valid", {31'b0, res_valid}, 32'd0);
      check("postrst res_data", res_data, 32'd0);
      check("postrst req0_ready", {31'b0, req0_ready}, 32'd1);
      check("postrst req1_ready", {31'b0, req1_ready}, 32'd0);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      n = 1;
      while (!res_valid && n < 30) begin
         @(negedge clk); #1; n++;
      end
      check("postrst latency", n, 32'd9);
      check("postrst res_data", res_data, 32'h13162B32);
      check("postrst res_id", {31'b0, res_id}, 32'd0);
      @(negedge clk);

      // Random traffic with random back-pressure.
      reset_dut();
      run_model(1500, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
